// File: rtl/avalon_egress_reader.sv
// avalon_egress_reader: Avalon-MM read responder that drains the switch output FIFOs.
//
// Each port keeps a one-word show-ahead holding register, so every host read
// returns with a fixed one-cycle latency.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-high reset
//   chipselect  Avalon slave select
//   read        Avalon read strobe
//   address     word address: 0 status, 1..3 pop, 4..6 delivered, 7 underflow total
//   readdata    registered read response, updated the cycle after an accepted read
//   fifo_q      output FIFO data, port n at [n*DATA_W +: DATA_W] (non-show-ahead)
//   fifo_empty  FIFO empty flags
//   fifo_rdreq  FIFO dequeue requests
//
// Optional feature, macro EGRESS_IRQ_EN, adds these ports:
//   write       Avalon write strobe (only address 8 is decoded here)
//   writedata   write data, bits [NPORTS-1:0] load irq_mask
//   irq         registered interrupt, |(hold_valid & irq_mask)
module avalon_egress_reader #(
    parameter int NPORTS = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W = 16,
    parameter logic [DATA_W-1:0] UNDERFLOW_WORD = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic [3:0]               address,
    output logic [DATA_W-1:0]        readdata,
    input  logic [NPORTS*DATA_W-1:0] fifo_q,
    input  logic [NPORTS-1:0]        fifo_empty,
    output logic [NPORTS-1:0]        fifo_rdreq
`ifdef EGRESS_IRQ_EN
    ,
    input  logic                     write,
    input  logic [DATA_W-1:0]        writedata,
    output logic                     irq
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;
    state_t            state_q [NPORTS];
    state_t            state_d [NPORTS];
    logic [DATA_W-1:0] hold_q [NPORTS];
    logic [CNT_W-1:0]  dlv_q [NPORTS];
    logic [CNT_W-1:0]  ufl_q;
    logic [NPORTS-1:0] sticky_q;
    logic [NPORTS-1:0] hold_valid;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] uflow;
    logic [DATA_W-1:0] rd_mux;
    logic              acc;
`ifdef EGRESS_IRQ_EN
    logic [NPORTS-1:0] irq_mask_q;
`endif
    assign acc = chipselect && read;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NPORTS; n++) state_q[n] <= IDLE;
        end else begin
            for (int n = 0; n < NPORTS; n++) state_q[n] <= state_d[n];
        end
    end
    always_comb begin
        fifo_rdreq = '0;
        pop = '0;
        hold_valid = '0;
        uflow = '0;
        for (int n = 0; n < NPORTS; n++) begin
            state_d[n] = state_q[n];
            pop[n] = acc && (address == 4'(n + 1));
            hold_valid[n] = state_q[n] == FULL;
            uflow[n] = pop[n] && !hold_valid[n];
            case (state_q[n])
                IDLE: begin
                    fifo_rdreq[n] = !fifo_empty[n];
                    state_d[n] = fifo_empty[n] ? IDLE : WAIT;
                end
                WAIT: state_d[n] = FULL;
                FULL: begin
                    // Refill in the same cycle as the pop so the next word lands one cycle later.
                    fifo_rdreq[n] = pop[n] && !fifo_empty[n];
                    state_d[n] = !pop[n] ? FULL : (fifo_empty[n] ? IDLE : WAIT);
                end
                default: state_d[n] = IDLE;
            endcase
        end
        // Keep the FIFOs untouched while reset is held, since the FSMs are parked in IDLE.
        if (reset) fifo_rdreq = '0;
    end
    always_comb begin
        rd_mux = '0;
        if (address == 4'd0) rd_mux[3*NPORTS-1:0] = {sticky_q, fifo_empty, hold_valid};
        for (int n = 0; n < NPORTS; n++) begin
            if (address == 4'(n + 1)) rd_mux = hold_valid[n] ? hold_q[n] : UNDERFLOW_WORD;
            if (address == 4'(n + 1 + NPORTS)) rd_mux = DATA_W'(dlv_q[n]);
        end
        if (address == 4'(2 * NPORTS + 1)) rd_mux = DATA_W'(ufl_q);
`ifdef EGRESS_IRQ_EN
        if (address == 4'd8) rd_mux = DATA_W'(irq_mask_q);
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NPORTS; n++) begin
                hold_q[n] <= '0;
                dlv_q[n] <= '0;
            end
            sticky_q <= '0;
            ufl_q <= '0;
            readdata <= '0;
        end else begin
            for (int n = 0; n < NPORTS; n++) begin
                if (state_q[n] == WAIT) hold_q[n] <= fifo_q[n*DATA_W +: DATA_W];
                if (pop[n] && hold_valid[n]) dlv_q[n] <= dlv_q[n] + CNT_W'(1);
            end
            if (acc) readdata <= rd_mux;
            // A new underflow wins over the clear-on-read of the status word.
            sticky_q <= ((acc && address == 4'd0) ? '0 : sticky_q) | uflow;
            if (|uflow) ufl_q <= ufl_q + CNT_W'(1);
        end
    end
`ifdef EGRESS_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q <= '1;
            irq <= 1'b0;
        end else begin
            if (chipselect && write && address == 4'd8) irq_mask_q <= writedata[NPORTS-1:0];
            irq <= |(hold_valid & irq_mask_q);
        end
    end
`endif
endmodule

// File: tb/tb_avalon_egress_reader.sv
// tb_avalon_egress_reader: scoreboard bench for avalon_egress_reader with a FIFO model.
module tb_avalon_egress_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic [3:0]  address = '0;
    logic [31:0] readdata;
    logic [95:0] fifo_q = '0;
    logic [2:0]  fifo_empty;
    logic [2:0]  fifo_rdreq;
`ifdef EGRESS_IRQ_EN
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        irq;
`endif
    int total = 0;
    int bad = 0;
    int viol = 0;
    logic [31:0] exp_q[$];
    logic        acc_d = 1'b0;
    logic [2:0]  rq_d = '0;
    logic [31:0] mem [3][8];
    int          rp [3] = '{0, 0, 0};
    int          wp [3] = '{0, 0, 0};

    avalon_egress_reader dut (
        .clk(clk),
        .reset(reset),
        .chipselect(chipselect),
        .read(read),
        .address(address),
        .readdata(readdata),
        .fifo_q(fifo_q),
        .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq)
`ifdef EGRESS_IRQ_EN
        ,
        .write(write),
        .writedata(writedata),
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = {rp[2] == wp[2], rp[1] == wp[1], rp[0] == wp[0]};

    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (fifo_rdreq[n] && (rp[n] == wp[n] || rq_d[n])) viol <= viol + 1;
            if (fifo_rdreq[n] && rp[n] != wp[n]) begin
                fifo_q[n*32 +: 32] <= mem[n][rp[n] % 8];
                rp[n] <= rp[n] + 1;
            end
        end
        rq_d <= fifo_rdreq;
        acc_d <= chipselect && read && !reset;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (acc_d) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("readdata", readdata, exp_q.pop_front());
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        chipselect = 1'b1;
        read = 1'b1;
        address = a;
        exp_q.push_back(e);
        tick();
        chipselect = 1'b0;
        read = 1'b0;
        address = '0;
    endtask

    task automatic push(input int n, input logic [31:0] w);
        mem[n][wp[n] % 8] = w;
        wp[n] = wp[n] + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        reset = 1'b0;
        tick();
        chk("rst_readdata", readdata, 32'd0);
        push(0, 32'hAAAA_0001);
        tick();
        reset = 1'b1;
        #1;
        chk("rst_wait_readdata", readdata, 32'd0);
        chk("rst_wait_rdreq", 32'(fifo_rdreq), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        rd(4'd0, 32'h038);
        for (int a = 4; a < 8; a++) rd(4'(a), 32'd0);
        push(0, 32'h1234_5678);
        #1;
        chk("single_rdreq_on", 32'(fifo_rdreq), 32'b001);
        tick();
        chk("single_rdreq_off", 32'(fifo_rdreq), 32'd0);
        tick();
        rd(4'd0, 32'h039);
        rd(4'd1, 32'h1234_5678);
        rd(4'd4, 32'd1);
        rd(4'd0, 32'h038);
        push(1, 32'hA0A0_0001);
        push(1, 32'hB0B0_0002);
        push(1, 32'hC0C0_0003);
        tick(2);
        rd(4'd2, 32'hA0A0_0001);
        tick(2);
        rd(4'd2, 32'hB0B0_0002);
        tick(2);
        rd(4'd2, 32'hC0C0_0003);
        rd(4'd5, 32'd3);
        rd(4'd7, 32'd0);
        rd(4'd0, 32'h038);
        rd(4'd3, 32'hDEAD_BEEF);
        rd(4'd0, 32'h138);
        rd(4'd7, 32'd1);
        rd(4'd0, 32'h038);
        push(0, 32'h5555_0000);
        push(0, 32'h5555_0001);
        tick(2);
        rd(4'd1, 32'h5555_0000);
        rd(4'd1, 32'hDEAD_BEEF);
        tick();
        rd(4'd1, 32'h5555_0001);
        rd(4'd4, 32'd3);
        rd(4'd7, 32'd2);
        read = 1'b1;
        address = 4'd4;
        tick();
        read = 1'b0;
        tick();
        chk("read_no_cs_hold", readdata, 32'd2);
        rd(4'd0, 32'h078);
        rd(4'd0, 32'h038);
        rd(4'd9, 32'd0);
        rd(4'd15, 32'd0);
`ifdef EGRESS_IRQ_EN
        rd(4'd8, 32'h7);
        chipselect = 1'b1;
        write = 1'b1;
        address = 4'd8;
        writedata = 32'h2;
        tick();
        chipselect = 1'b0;
        write = 1'b0;
        rd(4'd8, 32'h2);
        push(0, 32'h0000_00A0);
        tick(3);
        chk("irq_masked", 32'(irq), 32'd0);
        push(1, 32'h0000_00B1);
        tick(3);
        chk("irq_rise", 32'(irq), 32'd1);
        rd(4'd2, 32'h0000_00B1);
        tick();
        chk("irq_fall", 32'(irq), 32'd0);
        rd(4'd1, 32'h0000_00A0);
`else
        rd(4'd8, 32'd0);
`endif
        tick(3);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("rdreq_rules", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avalon_egress_reader.md
Name: avalon_egress_reader

Overview:
- Avalon-MM read-side responder for the packet switch: drains the three switch output FIFOs and returns their words to userspace over readdata.
- Pairs with the existing write path, which enqueues to the input FIFOs.
- Keeps a one-word show-ahead holding register per port, so every host read completes with a fixed latency of 1 cycle.
- Provides status, per-port delivered counters and underflow tracking.

Parameters:
- NPORTS, 3, number of output FIFOs drained (address map below fixed for 3).
- DATA_W, 32, FIFO word and readdata width.
- CNT_W, 16, width of delivered/underflow counters.
- UNDERFLOW_WORD, 32'hDEAD_BEEF, value returned on a pop from a port with no valid word.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe.
- address  in  4  word address.
- readdata  out  DATA_W  read response, valid the cycle after the accepted read.
- fifo_q  in  NPORTS*DATA_W  output FIFO data, port n at bits [n*DATA_W +: DATA_W]; non-show-ahead, valid 1 cycle after rdreq.
- fifo_empty  in  NPORTS  FIFO empty flags.
- fifo_rdreq  out  NPORTS  FIFO dequeue requests.

Behaviour:
- Reset (async, active-high):
  - readdata=0, fifo_rdreq=0, all ports in IDLE.
  - Holding registers, counters and sticky flags are cleared.
  - If a rdreq was issued the cycle before reset, that word is discarded; the FIFO is reset by the system separately.
- Accepted read: chipselect && read in cycle T. readdata is registered and updated in T+1, then holds its value until the next accepted read.
- Address map:
  - 0 = status. Bits [2:0] hold-valid per port, [5:3] fifo_empty, [8:6] sticky underflow per port, rest 0. Reading address 0 clears bits [8:6] after returning them.
  - 1..3 = pop port 0..2.
  - 4..6 = delivered count, port 0..2.
  - 7 = total underflow count.
  - Counts are zero-extended and wrap mod 2^CNT_W.
  - 8..15 return 0 with no side effect.
- Per-port FSM states: IDLE (hold empty), WAIT (rdreq issued last cycle), FULL (hold valid).
  - IDLE: if !fifo_empty, assert fifo_rdreq for exactly 1 cycle and go to WAIT.
  - WAIT: capture fifo_q into hold, go to FULL. fifo_rdreq=0.
  - FULL with a pop: readdata<=hold, delivered count +1. If !fifo_empty, assert fifo_rdreq that same cycle and go to WAIT; else go to IDLE.
  - FULL without a pop: stay in FULL.
- Pop while IDLE or WAIT (underflow):
  - readdata<=UNDERFLOW_WORD.
  - Sticky bit for that port set; underflow count +1.
  - FSM is unaffected: a WAIT capture still completes.
- fifo_rdreq is never asserted while fifo_empty=1, and never in two consecutive cycles for one port. Each port has at most one outstanding word.
- Ports are independent. A status read and a sticky set in the same cycle: the set wins, and the bit reads as 1 next time.
- Back-to-back pops on one port:
  - Sustained rate is 1 word per 2 cycles.
  - A pop in the cycle after a pop finds the port in WAIT and underflows.
  - Software polls status bit [n] before popping.
- read without chipselect is ignored. There is no write port; writes to this slave are decoded elsewhere.

Optional Feature:
- Macro EGRESS_IRQ_EN.
- When defined:
  - Adds output irq (1 bit), registered, reset 0.
  - irq=1 in the cycle after any port enters FULL, and stays 1 while any hold is valid.
  - Also adds an irq_mask register, NPORTS bits, reset all 1. It is read at address 8 and loaded from writedata[NPORTS-1:0] when chipselect && write && address==8; this adds inputs write (1) and writedata (DATA_W).
  - irq = |(hold_valid & irq_mask).
- When undefined: no irq, write or writedata ports, and address 8 reads 0.

Test Plan:
- Reset check: assert reset mid-WAIT -> readdata=0, fifo_rdreq=0, status read returns 0x038 with all FIFOs empty, and all counters read 0.
- Single word: FIFO0 supplies 0x12345678 -> rdreq0 pulses for one cycle, status bit0=1 two cycles later. Pop at address 1 -> readdata=0x12345678 the next cycle, and address 4 reads 1.
- Refill: FIFO1 holds 3 words A,B,C; pop address 2 every 3 cycles -> returns A,B,C in order, with no underflow and delivered count 3.
- Underflow: pop address 3 with FIFO2 empty -> readdata=0xDEADBEEF, status bit8=1 and address 7 reads 1. A second status read shows bit8=0.
- Back-to-back pops on port 0 with 2 words queued -> first pop returns word0, second (WAIT) returns 0xDEADBEEF, and a third pop 2 cycles later returns word1.
- EGRESS_IRQ_EN: with mask=0b010 written and words on ports 0 and 1 -> irq rises when port1 is FULL, ignores port0, and falls after port1 is popped.
